// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: frames RX bytes into ALU operations, returns 2-byte result LSB-first.
// Latency: FUN byte on edge k -> ALU_EN cycle k+1 -> TX_VALID (lo byte) from cycle k+3.
// Backpressure: TX bytes held stable while TX_BUSY=1; RX bytes arriving while busy are dropped with CMD_ERR.
module alu_cmd_ctrl #(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD,
   parameter int                    TIMEOUT     = 15
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_DATA,
   input  logic                      RX_VALID,
   output logic [DATA_WIDTH-1:0]     ALU_A,
   output logic [DATA_WIDTH-1:0]     ALU_B,
   output logic [3:0]                ALU_FUN,
   output logic                      ALU_EN,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      OUT_VALID,
   output logic [DATA_WIDTH-1:0]     TX_DATA,
   output logic                      TX_VALID,
   input  logic                      TX_BUSY,
   output logic                      CTRL_BUSY,
   output logic                      CMD_ERR
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_A    = 3'd1,
      GET_B    = 3'd2,
      GET_FUN  = 3'd3,
      ALU_REQ  = 3'd4,
      ALU_WAIT = 3'd5,
      SEND_LO  = 3'd6,
      SEND_HI  = 3'd7
   } state_t;

   state_t                  state;
   logic [TW-1:0]           tmo_cnt;
   logic [2*DATA_WIDTH-1:0] result;
   logic [DATA_WIDTH-1:0]   alu_a;
   logic [DATA_WIDTH-1:0]   alu_b;
   logic [3:0]              alu_fun;
   logic                    alu_en;
   logic [DATA_WIDTH-1:0]   tx_data;
   logic                    tx_valid;
   logic                    ctrl_busy;
   logic                    cmd_err;

   // Frame FSM; every output is a flop, CTRL_BUSY is updated alongside each state change
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         result    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_fun   <= '0;
         alu_en    <= 1'b0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         ctrl_busy <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         alu_en  <= 1'b0;
         cmd_err <= 1'b0;
         case (state)
            IDLE: begin
               if (RX_VALID) begin
                  if (RX_DATA == CMD_ALU_OP) begin
                     state     <= GET_A;
                     ctrl_busy <= 1'b1;
                  end else if (RX_DATA == CMD_ALU_NOP) begin
                     state     <= GET_FUN;
                     ctrl_busy <= 1'b1;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            GET_A: begin
               if (RX_VALID) begin
                  alu_a <= RX_DATA;
                  state <= GET_B;
               end
            end
            GET_B: begin
               if (RX_VALID) begin
                  alu_b <= RX_DATA;
                  state <= GET_FUN;
               end
            end
            GET_FUN: begin
               if (RX_VALID) begin
                  alu_fun <= RX_DATA[3:0];
                  alu_en  <= 1'b1;
                  state   <= ALU_REQ;
               end
            end
            ALU_REQ: begin
               tmo_cnt <= '0;
               state   <= ALU_WAIT;
            end
            ALU_WAIT: begin
               if (OUT_VALID) begin
                  result   <= ALU_OUT;
                  tx_data  <= ALU_OUT[DATA_WIDTH-1:0];
                  tx_valid <= 1'b1;
                  state    <= SEND_LO;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  cmd_err   <= 1'b1;
                  state     <= IDLE;
                  ctrl_busy <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            SEND_LO: begin
               // tx_valid is always high here; drop it on the accept edge to force a gap
               if (!TX_BUSY) begin
                  tx_valid <= 1'b0;
                  state    <= SEND_HI;
               end
            end
            SEND_HI: begin
               if (!tx_valid) begin
                  tx_valid <= 1'b1;
                  tx_data  <= result[2*DATA_WIDTH-1:DATA_WIDTH];
               end else if (!TX_BUSY) begin
                  tx_valid  <= 1'b0;
                  state     <= IDLE;
                  ctrl_busy <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               ctrl_busy <= 1'b0;
            end
         endcase
         // bytes arriving while an operation is in flight are discarded
         if (RX_VALID && (state inside {ALU_REQ, ALU_WAIT, SEND_LO, SEND_HI}))
            cmd_err <= 1'b1;
      end
   end

   assign ALU_A     = alu_a;
   assign ALU_B     = alu_b;
   assign ALU_FUN   = alu_fun;
   assign ALU_EN    = alu_en;
   assign TX_DATA   = tx_data;
   assign TX_VALID  = tx_valid;
   assign CTRL_BUSY = ctrl_busy;
   assign CMD_ERR   = cmd_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a 1-cycle registered ALU model and a TX byte monitor.
// Inputs change 2 time units after the rising edge; the monitor samples on the falling edge.
// Expected bytes are hand-computed constants.
module tb_alu_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_fun;
   logic        alu_en;
   logic [15:0] alu_out;
   logic        out_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_busy;
   logic        ctrl_busy;
   logic        cmd_err;

   logic        alu_stall;
   int          errors = 0;
   int          checks = 0;

   logic [7:0]  tx_q[$];
   int          en_cnt = 0;
   int          err_cnt = 0;
   int          viol = 0;
   logic [7:0]  en_a, en_b;
   logic [3:0]  en_fun;
   logic        prev_pend, prev_acc;
   logic [7:0]  prev_data;

   alu_cmd_ctrl dut (
      .CLK       (clk),
      .RST       (rst),
      .RX_DATA   (rx_data),
      .RX_VALID  (rx_valid),
      .ALU_A     (alu_a),
      .ALU_B     (alu_b),
      .ALU_FUN   (alu_fun),
      .ALU_EN    (alu_en),
      .ALU_OUT   (alu_out),
      .OUT_VALID (out_valid),
      .TX_DATA   (tx_data),
      .TX_VALID  (tx_valid),
      .TX_BUSY   (tx_busy),
      .CTRL_BUSY (ctrl_busy),
      .CMD_ERR   (cmd_err)
   );

   always #5 clk = ~clk;

   // ALU model: 0 add, 1 sub, 2 mul, result one cycle after enable
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         alu_out   <= 16'h0000;
      end else begin
         out_valid <= alu_en & ~alu_stall;
         if (alu_en) begin
            case (alu_fun)
               4'd0:    alu_out <= {8'h00, alu_a} + {8'h00, alu_b};
               4'd1:    alu_out <= {8'h00, alu_a} - {8'h00, alu_b};
               4'd2:    alu_out <= {8'h00, alu_a} * {8'h00, alu_b};
               default: alu_out <= 16'h0000;
            endcase
         end
      end
   end

   // Monitor: accepted bytes, enable/error pulses, TX hold and gap rules
   always @(negedge clk) begin
      if (!rst) begin
         prev_pend <= 1'b0;
         prev_acc  <= 1'b0;
      end else begin
         if (prev_pend && (!tx_valid || tx_data !== prev_data)) viol <= viol + 1;
         if (prev_acc && tx_valid) viol <= viol + 1;
         prev_pend <= tx_valid && tx_busy;
         prev_acc  <= tx_valid && !tx_busy;
         prev_data <= tx_data;
         if (tx_valid && !tx_busy) tx_q.push_back(tx_data);
         if (alu_en) begin
            en_cnt <= en_cnt + 1;
            en_a   <= alu_a;
            en_b   <= alu_b;
            en_fun <= alu_fun;
         end
         if (cmd_err) err_cnt <= err_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (tx_valid !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(tx_valid), 32'd1);
   endtask

   task automatic wait_tx(input int nb, input string tag);
      int n = 0;
      while (tx_q.size() < nb && n < 100) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(tx_q.size()), 32'(nb));
   endtask

   initial begin
      int n;
      int e0;
      int en0;
      rst       = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      tx_busy   = 1'b0;
      alu_stall = 1'b0;
      #3 rst = 1'b0;
      tick(2);
      chk("reset_outputs", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, ctrl_busy, cmd_err}, 32'h0);
      rst = 1'b1;
      tick(2);

      // 1: 05 + 03
      tx_q.delete();
      en0 = en_cnt;
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
      chk("t1_en_high", 32'(alu_en), 32'd1);
      chk("t1_operands", {alu_a, alu_b, alu_fun}, {8'h05, 8'h03, 4'h0});
      tick(1);
      chk("t1_en_low", {alu_en, tx_valid}, 32'd0);
      tick(1);
      chk("t1_lo_latency", {tx_valid, tx_data}, {1'b1, 8'h08});
      wait_tx(2, "t1_count");
      chk("t1_bytes", {tx_q[0], tx_q[1]}, 32'h0800);
      chk("t1_en_pulses", 32'(en_cnt - en0), 32'd1);
      tick(1);
      chk("t1_idle", 32'(ctrl_busy), 32'd0);

      // 2: FF * FF, then reused operands with add
      tx_q.delete();
      send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
      wait_tx(2, "t2_mul_count");
      chk("t2_mul_bytes", {tx_q[0], tx_q[1]}, 32'h01FE);
      tick(2);
      tx_q.delete();
      send_byte(8'hDD); send_byte(8'h00);
      wait_tx(2, "t2_nop_count");
      chk("t2_nop_bytes", {tx_q[0], tx_q[1]}, 32'hFE01);
      chk("t2_nop_operands", {en_a, en_b, en_fun}, {8'hFF, 8'hFF, 4'h0});
      tick(2);

      // 3: illegal opcode then a good frame
      e0  = err_cnt;
      en0 = en_cnt;
      send_byte(8'h7A);
      chk("t3_err_now", {cmd_err, ctrl_busy}, 32'h2);
      tick(3);
      chk("t3_err_pulses", 32'(err_cnt - e0), 32'd1);
      chk("t3_no_en", 32'(en_cnt - en0), 32'd0);
      chk("t3_idle", 32'(ctrl_busy), 32'd0);
      tx_q.delete();
      send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'hF0);
      wait_tx(2, "t3_count");
      chk("t3_bytes", {tx_q[0], tx_q[1]}, 32'h0300);
      tick(2);

      // 4: ALU never answers
      tx_q.delete();
      alu_stall = 1'b1;
      send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h01);
      n = 0;
      while (cmd_err !== 1'b1 && n < 40) begin
         tick(1);
         n++;
      end
      chk("t4_timeout_cycles", 32'(n), 32'd16);
      chk("t4_idle", 32'(ctrl_busy), 32'd0);
      tick(3);
      chk("t4_no_tx", 32'(tx_q.size()), 32'd0);
      alu_stall = 1'b0;

      // 5: backpressure on both bytes; 07 - 09 = FFFE
      tx_q.delete();
      tx_busy = 1'b1;
      send_byte(8'hCC); send_byte(8'h07); send_byte(8'h09); send_byte(8'h01);
      wait_valid("t5_lo_valid");
      tick(10);
      chk("t5_lo_held", {tx_valid, tx_data}, {1'b1, 8'hFE});
      tx_busy = 1'b0;
      tick(1);
      tx_busy = 1'b1;
      wait_valid("t5_hi_valid");
      chk("t5_hi_data", 32'(tx_data), 32'hFF);
      e0 = err_cnt;
      send_byte(8'h55);
      chk("t5_rx_in_send", {cmd_err, tx_valid, tx_data, ctrl_busy}, {1'b1, 1'b1, 8'hFF, 1'b1});
      tx_busy = 1'b0;
      wait_tx(2, "t5_count");
      chk("t5_bytes", {tx_q[0], tx_q[1]}, 32'hFEFF);
      chk("t5_err_pulses", 32'(err_cnt - e0), 32'd1);
      tick(2);

      // 6: reset in GET_B, then in SEND_HI
      send_byte(8'hCC); send_byte(8'h11);
      rst = 1'b0;
      #1;
      chk("t6_reset_getb", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, ctrl_busy, cmd_err}, 32'h0);
      tick(1);
      rst = 1'b1;
      tick(1);
      tx_q.delete();
      send_byte(8'hCC); send_byte(8'h04); send_byte(8'h06); send_byte(8'h02);
      wait_tx(2, "t6_a_count");
      chk("t6_a_bytes", {tx_q[0], tx_q[1]}, 32'h1800);
      tick(2);
      tx_q.delete();
      tx_busy = 1'b1;
      send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
      wait_valid("t6_lo_valid");
      tx_busy = 1'b0;
      tick(1);
      tx_busy = 1'b1;
      wait_valid("t6_hi_valid");
      rst = 1'b0;
      #1;
      chk("t6_reset_sendhi", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, ctrl_busy, cmd_err}, 32'h0);
      tick(2);
      rst = 1'b1;
      tx_busy = 1'b0;
      tick(5);
      chk("t6_partial_dropped", 32'(tx_q.size()), 32'd1);
      tx_q.delete();
      send_byte(8'hCC); send_byte(8'h09); send_byte(8'h09); send_byte(8'h00);
      wait_tx(2, "t6_b_count");
      chk("t6_b_bytes", {tx_q[0], tx_q[1]}, 32'h1200);
      tick(2);

      chk("tx_hold_and_gap", 32'(viol), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
